// File: rtl/mult_pkg.sv
// mult_pkg: shared types, widths, shift constants and the magnitude helper for the HI/LO multiply unit.
package mult_pkg;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;
    localparam int ACC_W  = 64;
    localparam int SH_LL  = 0;
    localparam int SH_HL  = 16;
    localparam int SH_LH  = 16;
    localparam int SH_HH  = 32;

    typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, MUL3, FIX} state_t;

    // Negating 0x80000000 wraps to itself, which is the correct unsigned magnitude.
    function automatic logic [WORD_W-1:0] mag(input logic [WORD_W-1:0] v, input logic s);
        return (s & v[WORD_W-1]) ? -v : v;
    endfunction
endpackage

// File: rtl/umul16.sv
// umul16: 16x16 unsigned combinational multiplier core.
module umul16
    import mult_pkg::*;
(
    input  logic [HALF_W-1:0] A,
    input  logic [HALF_W-1:0] B,
    output logic [WORD_W-1:0] product
);
    assign product = {{HALF_W{1'b0}}, A} * {{HALF_W{1'b0}}, B};
endmodule

// File: rtl/mult_hilo_unit.sv
// mult_hilo_unit: four-cycle 32x32 MULT/MULTU over one 16x16 core, with architectural HI/LO and MTHI/MTLO.
// Optional MULT_ACC_EN adds an accumulate input for MADD/MADDU behaviour.
module mult_hilo_unit
    import mult_pkg::*;
#(
    parameter int SKIP_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_signed,
    input  logic [WORD_W-1:0] op_a,
    input  logic [WORD_W-1:0] op_b,
    input  logic              wr_hi,
    input  logic              wr_lo,
    input  logic [WORD_W-1:0] wr_data,
`ifdef MULT_ACC_EN
    input  logic              accumulate,
`endif
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo
);
    state_t            r_state, w_next;
    logic [WORD_W-1:0] r_mag_a, r_mag_b, r_hi, r_lo;
    logic              r_neg, r_done;
    logic [ACC_W-1:0]  r_acc;
    logic [HALF_W-1:0] w_a, w_b;
    logic [WORD_W-1:0] w_prod;
    logic [ACC_W-1:0]  w_pp, w_res, w_fix;
    logic              w_zero;
    int                w_sh;

    assign w_zero = (op_a == '0) || (op_b == '0);
    assign w_a    = (r_state == MUL1 || r_state == MUL3) ? r_mag_a[WORD_W-1:HALF_W] : r_mag_a[HALF_W-1:0];
    assign w_b    = (r_state == MUL2 || r_state == MUL3) ? r_mag_b[WORD_W-1:HALF_W] : r_mag_b[HALF_W-1:0];
    assign w_pp   = {{WORD_W{1'b0}}, w_prod} << w_sh;
    assign w_res  = r_neg ? (~r_acc + 64'd1) : r_acc;

`ifdef MULT_ACC_EN
    logic r_accum;
    assign w_fix = r_accum ? ({r_hi, r_lo} + w_res) : w_res;
`else
    assign w_fix = w_res;
`endif

    umul16 u_core (.A(w_a), .B(w_b), .product(w_prod));

    always_comb begin
        w_next = r_state;
        w_sh   = SH_LL;
        case (r_state)
            IDLE:    w_next = start ? ((SKIP_ZERO != 0 && w_zero) ? FIX : MUL0) : IDLE;
            MUL0:    w_next = MUL1;
            MUL1:    begin w_next = MUL2; w_sh = SH_HL; end
            MUL2:    begin w_next = MUL3; w_sh = SH_LH; end
            MUL3:    begin w_next = FIX;  w_sh = SH_HH; end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
            r_acc   <= '0;
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_neg   <= 1'b0;
`ifdef MULT_ACC_EN
            r_accum <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == FIX);
            case (r_state)
                IDLE: begin
                    if (wr_hi) r_hi <= wr_data;
                    if (wr_lo) r_lo <= wr_data;
                    if (start) begin
                        r_mag_a <= mag(op_a, is_signed);
                        r_mag_b <= mag(op_b, is_signed);
                        r_neg   <= is_signed & (op_a[WORD_W-1] ^ op_b[WORD_W-1]);
                        r_acc   <= '0;
`ifdef MULT_ACC_EN
                        r_accum <= accumulate;
`endif
                    end
                end
                FIX:     {r_hi, r_lo} <= w_fix;
                default: r_acc <= r_acc + w_pp;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule

// File: tb/tb_mult_hilo_unit.sv
// tb_mult_hilo_unit: scoreboard bench driving a SKIP_ZERO=1 and a SKIP_ZERO=0 instance side by side.
module tb_mult_hilo_unit;
    logic        clk = 1'b0;
    logic        rst, start, is_signed, wr_hi, wr_lo;
    logic [31:0] op_a, op_b, wr_data;
`ifdef MULT_ACC_EN
    logic        accumulate;
`endif
    logic        busy0, done0, busy1, done1;
    logic [31:0] hi0, lo0, hi1, lo1;
    int          passed = 0;
    int          total = 0;
    logic [63:0] q[$];
    logic [31:0] m_hi = 0;
    logic [31:0] m_lo = 0;

    always #5 clk = ~clk;

    mult_hilo_unit #(.SKIP_ZERO(1)) u0 (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .op_a(op_a), .op_b(op_b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
`ifdef MULT_ACC_EN
        .accumulate(accumulate),
`endif
        .busy(busy0), .done(done0), .hi(hi0), .lo(lo0));

    mult_hilo_unit #(.SKIP_ZERO(0)) u1 (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .op_a(op_a), .op_b(op_b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
`ifdef MULT_ACC_EN
        .accumulate(accumulate),
`endif
        .busy(busy1), .done(done1), .hi(hi1), .lo(lo1));

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ea, eb;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mt(input logic h, input logic l, input logic [31:0] d);
        wr_hi = h;
        wr_lo = l;
        wr_data = d;
        step();
        wr_hi = 0;
        wr_lo = 0;
        if (h) m_hi = d;
        if (l) m_lo = d;
        total++; if ({hi0, lo0} !== {m_hi, m_lo}) $display("FAIL mt0 got %h_%h want %h_%h", hi0, lo0, m_hi, m_lo); else passed++;
        total++; if ({hi1, lo1} !== {m_hi, m_lo}) $display("FAIL mt1 got %h_%h want %h_%h", hi1, lo1, m_hi, m_lo); else passed++;
    endtask

    task automatic mul(input logic [31:0] a, input logic [31:0] b, input logic s, input logic acc);
        logic [63:0] e, r0, r1;
        int lat0, l0, l1, d0, d1, bad;
        e = acc ? ({m_hi, m_lo} + model(a, b, s)) : model(a, b, s);
        q.push_back(e);
        {m_hi, m_lo} = e;
        lat0 = (a == 0 || b == 0) ? 2 : 6;
        op_a = a; op_b = b; is_signed = s; start = 1;
`ifdef MULT_ACC_EN
        accumulate = acc;
`endif
        step();
        start = 0;
`ifdef MULT_ACC_EN
        accumulate = 0;
`endif
        l0 = 0; l1 = 0; d0 = 0; d1 = 0; bad = 0; r0 = '0; r1 = '0;
        for (int n = 1; n <= 12; n++) begin
            if (busy0 !== (n < lat0)) bad++;
            if (busy1 !== (n < 6)) bad++;
            if (done0) begin d0++; if (l0 == 0) begin l0 = n; r0 = {hi0, lo0}; end end
            if (done1) begin d1++; if (l1 == 0) begin l1 = n; r1 = {hi1, lo1}; end end
            if (l0 != 0 && l1 != 0) break;
            step();
        end
        e = q.pop_front();
        total++; if (r0 !== e) $display("FAIL mul_res0 %h*%h got %h want %h", a, b, r0, e); else passed++;
        total++; if (r1 !== e) $display("FAIL mul_res1 %h*%h got %h want %h", a, b, r1, e); else passed++;
        total++; if (l0 != lat0) $display("FAIL mul_lat0 got %0d want %0d", l0, lat0); else passed++;
        total++; if (l1 != 6) $display("FAIL mul_lat1 got %0d want 6", l1); else passed++;
        total++; if (bad != 0) $display("FAIL mul_busy got %0d bad cycles want 0", bad); else passed++;
        total++; if (d0 != 1 || d1 != 1) $display("FAIL mul_done_pulses got %0d/%0d want 1/1", d0, d1); else passed++;
    endtask

    task automatic test_reset();
        rst = 1; start = 0; is_signed = 0; op_a = 0; op_b = 0; wr_hi = 0; wr_lo = 0; wr_data = 0;
`ifdef MULT_ACC_EN
        accumulate = 0;
`endif
        step(); step();
        rst = 0;
        total++; if ({busy0, done0, hi0, lo0} !== 66'b0) $display("FAIL reset0 got %b %b %h %h want 0", busy0, done0, hi0, lo0); else passed++;
        total++; if ({busy1, done1, hi1, lo1} !== 66'b0) $display("FAIL reset1 got %b %b %h %h want 0", busy1, done1, hi1, lo1); else passed++;
        m_hi = 0; m_lo = 0;
    endtask

    task automatic test_mult();
        mul(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        mul(32'hFFFFFFFD, 32'd5, 1, 0);
        mul(32'h80000000, 32'h80000000, 1, 0);
        mul(32'h80000000, 32'h80000000, 0, 0);
        mul(32'h12345678, 32'hDEADBEEF, 1, 0);
        for (int i = 0; i < 4; i++) mul($urandom, $urandom, 1'($urandom_range(0, 1)), 0);
    endtask

    task automatic test_skip();
        mul(32'h12345678, 32'h0, 1, 0);
        mul(32'h0, 32'h87654321, 0, 0);
    endtask

    task automatic test_back_to_back();
        mul(32'd7, 32'd9, 0, 0);
        mul(32'hFFFF0000, 32'h0000FFFF, 0, 0);
        mul(32'hFFFFFFFF, 32'd1, 1, 0);
    endtask

    task automatic test_hilo_writes();
        mt(1, 1, 32'h5A5A0F0F);
        mt(1, 0, 32'hAAAA5555);
    endtask

    task automatic test_busy_hazard();
        logic [63:0] e;
        int l1, d;
        mul(32'd7, 32'd9, 0, 0);
        mt(1, 0, 32'hAAAA5555);
        e = model(32'd5, 32'd6, 0);
        q.push_back(e);
        op_a = 5; op_b = 6; is_signed = 0; start = 1;
        step();
        op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; is_signed = 1; wr_lo = 1; wr_data = 32'h1234;
        step();
        start = 0; wr_lo = 0;
        total++; if ({hi0, lo0} !== {32'hAAAA5555, m_lo}) $display("FAIL hazard_hold0 got %h_%h want aaaa5555_%h", hi0, lo0, m_lo); else passed++;
        total++; if ({hi1, lo1} !== {32'hAAAA5555, m_lo}) $display("FAIL hazard_hold1 got %h_%h want aaaa5555_%h", hi1, lo1, m_lo); else passed++;
        l1 = 0;
        for (int n = 2; n <= 12 && l1 == 0; n++) begin
            if (done1) l1 = n; else step();
        end
        e = q.pop_front();
        {m_hi, m_lo} = e;
        total++; if (l1 != 6) $display("FAIL hazard_lat got %0d want 6", l1); else passed++;
        total++; if ({hi0, lo0, hi1, lo1} !== {e, e}) $display("FAIL hazard_res got %h_%h want %h", hi1, lo1, e); else passed++;
        d = 0;
        for (int n = 0; n < 8; n++) begin step(); if (done0 || done1 || busy0 || busy1) d++; end
        total++; if (d != 0) $display("FAIL hazard_no_queue got %0d active cycles want 0", d); else passed++;
    endtask

    task automatic test_abort();
        int d;
        op_a = 32'd3; op_b = 32'd4; is_signed = 0; start = 1;
        step();
        start = 0;
        step(); step();
        rst = 1;
        step();
        rst = 0;
        m_hi = 0; m_lo = 0;
        total++; if ({busy0, done0, hi0, lo0} !== 66'b0) $display("FAIL abort0 got %b %b %h %h want 0", busy0, done0, hi0, lo0); else passed++;
        total++; if ({busy1, done1, hi1, lo1} !== 66'b0) $display("FAIL abort1 got %b %b %h %h want 0", busy1, done1, hi1, lo1); else passed++;
        d = 0;
        for (int n = 0; n < 8; n++) begin step(); if (done0 || done1) d++; end
        total++; if (d != 0) $display("FAIL abort_no_done got %0d want 0", d); else passed++;
        mul(32'h00010000, 32'h00010000, 0, 0);
    endtask

`ifdef MULT_ACC_EN
    task automatic test_accumulate();
        mt(1, 0, 32'h0);
        mt(0, 1, 32'hFFFFFFFF);
        mul(32'd1, 32'd1, 0, 1);
        mul(32'hFFFFFFFE, 32'd3, 1, 1);
        mul(32'h0, 32'd3, 1, 1);
    endtask
`endif

    initial begin
        test_reset();
        test_mult();
        test_skip();
        test_back_to_back();
        test_hilo_writes();
        test_busy_hazard();
        test_abort();
`ifdef MULT_ACC_EN
        test_accumulate();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
